// File: rtl/phase_timer.sv
// Phase interval timer: counts a per-phase duration (whole seconds) off the system
// clock and pulses `finished` so the sequencing FSM advances to its next phase.
module phase_timer #(
  parameter int CLK_HZ = 10000,
  parameter int SEC_W  = 16,
  parameter int PRE_W  = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [SEC_W-1:0] seconds_in,
  output logic             finished,
  output logic             busy,
  output logic [SEC_W-1:0] seconds_left,
  output logic             tick_1hz
);

  // Handshake with the sequencing FSM: `finished` is high for exactly the one DONE
  // cycle; the FSM registers its next duration on that same edge, so `seconds_in`
  // is only looked at (and must be valid) during the following LOAD cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DONE  = 2'd1,
    LOAD  = 2'd2,
    COUNT = 2'd3
  } state_t;

  localparam logic [PRE_W-1:0] RELOAD = PRE_W'(CLK_HZ - 1);

  state_t           state, state_next;
  logic [PRE_W-1:0] prescaler, prescaler_next;
  logic [SEC_W-1:0] seconds_next;
  logic             tick_next;

  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    seconds_next   = seconds_left;
    tick_next      = 1'b0;

    // Dropping enable aborts the phase outright; there is no pause.
    if (!enable) begin
      state_next     = IDLE;
      prescaler_next = '0;
      seconds_next   = '0;
    end else begin
      case (state)
        IDLE: state_next = DONE;
        DONE: state_next = LOAD;
        LOAD: begin
          seconds_next   = seconds_in;
          prescaler_next = RELOAD;
          state_next     = (seconds_in == '0) ? DONE : COUNT;
        end
        COUNT: begin
          if (seconds_left == '0) begin
            // Unreachable in normal flow; guards against ever wrapping below zero.
            state_next = DONE;
          end else if (prescaler == '0) begin
            prescaler_next = RELOAD;
            seconds_next   = seconds_left - 1'b1;
            tick_next      = 1'b1;
            if (seconds_left == SEC_W'(1)) state_next = DONE;
          end else begin
            prescaler_next = prescaler - 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with `state`.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      prescaler    <= '0;
      seconds_left <= '0;
      tick_1hz     <= 1'b0;
      finished     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      prescaler    <= prescaler_next;
      seconds_left <= seconds_next;
      tick_1hz     <= tick_next;
      finished     <= (state_next == DONE);
      busy         <= (state_next == LOAD) || (state_next == COUNT);
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer at CLK_HZ=10 with a 4-bit seconds field,
// so the full-scale duration can be run end to end.
module tb_phase_timer;

  localparam int CLK_HZ = 10;
  localparam int SEC_W  = 4;
  localparam int PRE_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [SEC_W-1:0] seconds_in;
  logic             finished;
  logic             busy;
  logic [SEC_W-1:0] seconds_left;
  logic             tick_1hz;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected seconds_left value at each tick, in order.
  logic [SEC_W-1:0] exp_q[$];

  phase_timer #(.CLK_HZ(CLK_HZ), .SEC_W(SEC_W), .PRE_W(PRE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .seconds_in   (seconds_in),
    .finished     (finished),
    .busy         (busy),
    .seconds_left (seconds_left),
    .tick_1hz     (tick_1hz)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every tick must match the next expected seconds_left value.
  always @(negedge clk) begin
    if (tick_1hz === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick: got tick with seconds_left=%0d, expected no tick (t=%0t)",
                 seconds_left, $time);
      end else begin
        logic [SEC_W-1:0] e;
        e = exp_q.pop_front();
        if (seconds_left !== e) begin
          n_fail++;
          $display("FAIL tick_value: got seconds_left=%0d, expected %0d (t=%0t)",
                   seconds_left, e, $time);
        end
      end
    end
  end

  typedef struct {
    int n;
    int change_at;   // cycle into the phase at which seconds_in is disturbed (0 = never)
    int change_val;
    int exp_period;  // cycles from this finished to the next
    int exp_ticks;
    int exp_first;   // cycle of the first tick (0 = none)
  } vec_t;

  vec_t vecs[8];

  // Driver: called while finished is high; presents the duration for the coming
  // LOAD and runs until the next finished pulse (bounded).
  task automatic run_phase(input int idx, input vec_t v);
    int  cnt, ticks, first;
    bit  done;
    seconds_in = SEC_W'(v.n);
    for (int k = v.n - 1; k >= 0; k--) exp_q.push_back(SEC_W'(k));
    cnt = 0; ticks = 0; first = 0; done = 1'b0;
    while (!done && cnt < v.exp_period + 20) begin
      @(negedge clk);
      cnt++;
      if (cnt == v.change_at) seconds_in = SEC_W'(v.change_val);
      if (tick_1hz) begin
        ticks++;
        if (first == 0) first = cnt;
      end
      if (cnt == 2) check($sformatf("v%0d_seconds_after_load", idx), int'(seconds_left), v.n);
      if (finished) done = 1'b1;
    end
    check($sformatf("v%0d_period", idx), done ? cnt : -1, v.exp_period);
    check($sformatf("v%0d_ticks", idx), ticks, v.exp_ticks);
    check($sformatf("v%0d_first_tick", idx), first, v.exp_first);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_finished"}, int'(finished), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_seconds_left"}, int'(seconds_left), 0);
    check({tag, "_tick"}, int'(tick_1hz), 0);
  endtask

  initial begin
    int   cnt, fin_cnt;
    vec_t r;

    vecs[0] = '{n: 3,  change_at: 0,  change_val: 0,  exp_period: 32,  exp_ticks: 3,  exp_first: 12};
    vecs[1] = '{n: 0,  change_at: 0,  change_val: 0,  exp_period: 2,   exp_ticks: 0,  exp_first: 0};
    vecs[2] = '{n: 0,  change_at: 0,  change_val: 0,  exp_period: 2,   exp_ticks: 0,  exp_first: 0};
    vecs[3] = '{n: 1,  change_at: 0,  change_val: 0,  exp_period: 12,  exp_ticks: 1,  exp_first: 12};
    vecs[4] = '{n: 5,  change_at: 20, change_val: 1,  exp_period: 52,  exp_ticks: 5,  exp_first: 12};
    vecs[5] = '{n: 2,  change_at: 5,  change_val: 15, exp_period: 22,  exp_ticks: 2,  exp_first: 12};
    vecs[6] = '{n: 15, change_at: 0,  change_val: 0,  exp_period: 152, exp_ticks: 15, exp_first: 12};
    vecs[7] = '{n: 0,  change_at: 0,  change_val: 0,  exp_period: 2,   exp_ticks: 0,  exp_first: 0};

    // Reset with enable already high
    reset = 1'b1; enable = 1'b1; seconds_in = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");

    // Start-up: IDLE -> DONE on the first edge after release
    reset = 1'b0;
    @(negedge clk);
    check("startup_finished", int'(finished), 1);
    check("startup_busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) run_phase(i, vecs[i]);

    // Abort at seconds_left==2 of a 4-second phase
    seconds_in = SEC_W'(4);
    exp_q.push_back(SEC_W'(3));
    exp_q.push_back(SEC_W'(2));
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(busy && seconds_left == SEC_W'(2) && cnt > 2) && cnt < 60);
    check("abort_reached_two", cnt, 22);
    enable = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    check("abort_queue_drained", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("abort_held_busy", int'(busy), 0);

    // Re-enable: fresh finished after the first enabled edge, then a clean phase
    enable = 1'b1;
    @(negedge clk);
    check("restart_finished", int'(finished), 1);
    check("restart_tick", int'(tick_1hz), 0);
    r = '{n: 2, change_at: 0, change_val: 0, exp_period: 22, exp_ticks: 2, exp_first: 12};
    run_phase(8, r);

    // Reset mid-COUNT: phase dropped, no finished afterwards
    seconds_in = SEC_W'(3);
    exp_q.push_back(SEC_W'(2));
    repeat (15) @(negedge clk);
    check("midreset_seconds_before", int'(seconds_left), 2);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    enable = 1'b0;
    reset  = 1'b0;
    fin_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (finished) fin_cnt++;
    end
    check("midreset_no_finished", fin_cnt, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
